acc_c_responder: RTL

//   Responder endpoint of the accelerator C-bus (q request / p response channel).

---
 rtl/acc_rsp_pkg.sv | 48 ++++
 rtl/acc_rsp_serial_mul.sv | 70 +++++++
 rtl/acc_c_responder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_rsp_pkg.sv
// ---------------------------------------------------------------------------
// acc_rsp_pkg
//   Shared types for the accelerator C-bus responder:
//   - funct_e    : operation encoding taken from instruction bits [14:12]
//   - state_e    : responder FSM states (MUL only with ACC_C_RESPONDER_MUL_EN)
//   - buf_ctrl_t : control part of one request-buffer entry
//   - RdLsb / FunctLsb : field positions inside the 32-bit instruction
// ---------------------------------------------------------------------------
package acc_rsp_pkg;

  localparam int RdLsb      = 7;
  localparam int RdWidth    = 5;
  localparam int FunctLsb   = 12;
  localparam int FunctWidth = 3;

  typedef enum logic [FunctWidth-1:0] {
    FN_ADD  = 3'b000,
    FN_SUB  = 3'b001,
    FN_AND  = 3'b010,
    FN_XOR  = 3'b011,
    FN_ADD3 = 3'b100,
    FN_MUL  = 3'b101,
    FN_NOP  = 3'b110,
    FN_ILL  = 3'b111
  } funct_e;

`ifdef ACC_C_RESPONDER_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_MUL  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1
  } state_e;
`endif

  // Operand data and id widths are module parameters, so they live in
  // parallel arrays in the top; this struct holds the fixed-width part.
  typedef struct packed {
    logic                 addr_err;
    funct_e               funct;
    logic [RdWidth-1:0]   rd;
  } buf_ctrl_t;

endpackage

// File: rtl/acc_rsp_serial_mul.sv
// ---------------------------------------------------------------------------
// acc_rsp_serial_mul
//   Unsigned shift-add multiplier, one partial product per cycle.
//   The start cycle already performs the first step on the live operands, so
//   the full product sits in 'product' exactly DataWidth cycles after start;
//   'done' is high in that cycle.
// Ports
//   clk, rst_n         clock, asynchronous active-high reset (aborts a run)
//   start              load a/b and begin a multiplication
//   a, b               operands (sampled on start)
//   done               product valid this cycle
//   product            2*DataWidth-bit result
// ---------------------------------------------------------------------------
module acc_rsp_serial_mul #(
  parameter int DataWidth = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DataWidth-1:0]   a,
  input  logic [DataWidth-1:0]   b,
  output logic                   done,
  output logic [2*DataWidth-1:0] product
);

  localparam int CntWidth = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  logic                   running;
  logic [CntWidth-1:0]    steps_left;
  logic [DataWidth-1:0]   mcand;
  logic [2*DataWidth-1:0] prod;

  // Right-shifting multiplier: the multiplier occupies the low half and is
  // consumed LSB first while partial sums accumulate in the high half.
  function automatic logic [2*DataWidth-1:0] shift_add(
    input logic [2*DataWidth-1:0] p,
    input logic [DataWidth-1:0]   m
  );
    logic [DataWidth:0] upper;
    upper = {1'b0, p[2*DataWidth-1:DataWidth]} + (p[0] ? {1'b0, m} : '0);
    return {upper, p[DataWidth-1:1]};
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      running    <= 1'b0;
      steps_left <= '0;
      mcand      <= '0;
      prod       <= '0;
    end else if (start) begin
      running    <= 1'b1;
      steps_left <= CntWidth'(DataWidth - 1);
      mcand      <= a;
      prod       <= shift_add({{DataWidth{1'b0}}, b}, a);
    end else if (running) begin
      if (steps_left != '0) begin
        steps_left <= steps_left - 1'b1;
        prod       <= shift_add(prod, mcand);
      end else begin
        running <= 1'b0;
      end
    end
  end

  assign done    = running && (steps_left == '0);
  assign product = prod;

endmodule

// File: rtl/acc_c_responder.sv
// ---------------------------------------------------------------------------
// acc_c_responder
//   Responder endpoint of the accelerator C-bus. Requests are buffered in a
//   small circular FIFO, executed one at a time and answered in order with
//   the originating id and rd.
//
//   Build option: ACC_C_RESPONDER_MUL_EN enables the serial multiplier for
//   funct 101; without it funct 101 answers as an illegal op.
//
//   Reset: rst_n is asynchronous and ACTIVE-HIGH (legacy name kept).
//
// Ports
//   q_addr_i/q_data_*_i/q_id_i/q_valid_i/q_ready_o   request channel
//   p_data0_o/p_data1_o/p_dual_writeback_o/p_id_o/
//   p_rd_o/p_error_o/p_valid_o/p_ready_i              response channel
//   busy_o                                            buffer or FSM occupied
// ---------------------------------------------------------------------------
module acc_c_responder
  import acc_rsp_pkg::*;
#(
  parameter int          DataWidth = 32,
  parameter int          AddrWidth = 3,
  parameter int          IdWidth   = 1,
  parameter int unsigned OwnAddr   = 0,
  parameter int          Depth     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AddrWidth-1:0] q_addr_i,
  input  logic [31:0]          q_data_op_i,
  input  logic [DataWidth-1:0] q_data_arga_i,
  input  logic [DataWidth-1:0] q_data_argb_i,
  input  logic [DataWidth-1:0] q_data_argc_i,
  input  logic [IdWidth-1:0]   q_id_i,
  input  logic                 q_valid_i,
  output logic                 q_ready_o,
  output logic [DataWidth-1:0] p_data0_o,
  output logic [DataWidth-1:0] p_data1_o,
  output logic                 p_dual_writeback_o,
  output logic [IdWidth-1:0]   p_id_o,
  output logic [4:0]           p_rd_o,
  output logic                 p_error_o,
  output logic                 p_valid_o,
  input  logic                 p_ready_i,
  output logic                 busy_o
);

  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntWidth = $clog2(Depth + 1);

  typedef logic [PtrWidth-1:0] ptr_t;

  // ---------------- request buffer ----------------
  buf_ctrl_t            ctrl_mem [Depth];
  logic [IdWidth-1:0]   id_mem   [Depth];
  logic [DataWidth-1:0] a_mem    [Depth];
  logic [DataWidth-1:0] b_mem    [Depth];
  logic [DataWidth-1:0] c_mem    [Depth];

  ptr_t                 wr_ptr, rd_ptr;
  logic [CntWidth-1:0]  count;
  logic                 push, pop;

  buf_ctrl_t            head_ctrl;
  logic [IdWidth-1:0]   head_id;
  logic [DataWidth-1:0] head_a, head_b, head_c;

  // Only rd and funct are meaningful in the instruction word.
  logic unused_op_bits;
  assign unused_op_bits = ^{q_data_op_i[31:FunctLsb+FunctWidth],
                            q_data_op_i[RdLsb-1:0]};

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // No bypass: a full buffer refuses even when the head leaves this cycle.
  assign q_ready_o = (count != CntWidth'(Depth));
  assign push      = q_valid_i && q_ready_o;

  // NOTE: the entry storage is deliberately not reset; count and pointers
  // alone decide which entries are valid, so stale payload is never used.
  always_ff @(posedge clk) begin
    if (push) begin
      ctrl_mem[wr_ptr] <= '{
        addr_err: (q_addr_i != AddrWidth'(OwnAddr)),
        funct:    funct_e'(q_data_op_i[FunctLsb +: FunctWidth]),
        rd:       q_data_op_i[RdLsb +: RdWidth]
      };
      id_mem[wr_ptr] <= q_id_i;
      a_mem[wr_ptr]  <= q_data_arga_i;
      b_mem[wr_ptr]  <= q_data_argb_i;
      c_mem[wr_ptr]  <= q_data_argc_i;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_ctrl = ctrl_mem[rd_ptr];
  assign head_id   = id_mem[rd_ptr];
  assign head_a    = a_mem[rd_ptr];
  assign head_b    = b_mem[rd_ptr];
  assign head_c    = c_mem[rd_ptr];

  // ---------------- single-cycle ALU ----------------
  logic [DataWidth-1:0] alu_res;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    alu_res = '0;
    case (head_ctrl.funct)
      FN_ADD:  alu_res = head_a + head_b;
      FN_SUB:  alu_res = head_a - head_b;
      FN_AND:  alu_res = head_a & head_b;
      FN_XOR:  alu_res = head_a ^ head_b;
      FN_ADD3: alu_res = head_a + head_b + head_c;
      default: alu_res = '0;
    endcase
  end

  // ---------------- multiplier ----------------
`ifdef ACC_C_RESPONDER_MUL_EN
  logic                   mul_start, mul_done, load_mul;
  logic [2*DataWidth-1:0] mul_product;

  acc_rsp_serial_mul #(
    .DataWidth (DataWidth)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (head_a),
    .b       (head_b),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  // ---------------- control FSM ----------------
  state_e state_q, state_d;
  logic   load_alu, load_err;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load_alu = 1'b0;
    load_err = 1'b0;
`ifdef ACC_C_RESPONDER_MUL_EN
    mul_start = 1'b0;
    load_mul  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          // Address mismatch wins over decode, so even a NOP answers.
          if (head_ctrl.addr_err) begin
            load_err = 1'b1;
            state_d  = ST_RESP;
          end else begin
            case (head_ctrl.funct)
              FN_NOP: state_d = ST_IDLE;
              FN_ILL: begin
                load_err = 1'b1;
                state_d  = ST_RESP;
              end
`ifdef ACC_C_RESPONDER_MUL_EN
              FN_MUL: begin
                mul_start = 1'b1;
                state_d   = ST_MUL;
              end
`else
              FN_MUL: begin
                load_err = 1'b1;
                state_d  = ST_RESP;
              end
`endif
              default: begin
                load_alu = 1'b1;
                state_d  = ST_RESP;
              end
            endcase
          end
        end
      end
`ifdef ACC_C_RESPONDER_MUL_EN
      ST_MUL: begin
        if (mul_done) begin
          load_mul = 1'b1;
          state_d  = ST_RESP;
        end
      end
`endif
      ST_RESP: begin
        if (p_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- response registers ----------------
  // Loaded only from IDLE/MUL, so they hold still for the whole RESP stall.
  logic [DataWidth-1:0] data0_q, data1_q;
  logic                 dual_q, err_q;
  logic [IdWidth-1:0]   rsp_id_q;
  logic [4:0]           rsp_rd_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      data0_q  <= '0;
      data1_q  <= '0;
      dual_q   <= 1'b0;
      err_q    <= 1'b0;
      rsp_id_q <= '0;
      rsp_rd_q <= '0;
    end else begin
      if (pop) begin
        rsp_id_q <= head_id;
        rsp_rd_q <= head_ctrl.rd;
      end
      if (load_err) begin
        data0_q <= '0;
        data1_q <= '0;
        dual_q  <= 1'b0;
        err_q   <= 1'b1;
      end else if (load_alu) begin
        data0_q <= alu_res;
        data1_q <= '0;
        dual_q  <= 1'b0;
        err_q   <= 1'b0;
      end
`ifdef ACC_C_RESPONDER_MUL_EN
      else if (load_mul) begin
        {data1_q, data0_q} <= mul_product;
        dual_q             <= 1'b1;
        err_q              <= 1'b0;
      end
`endif
    end
  end

  assign p_data0_o          = data0_q;
  assign p_data1_o          = data1_q;
  assign p_dual_writeback_o = dual_q;
  assign p_id_o             = rsp_id_q;
  assign p_rd_o             = rsp_rd_q;
  assign p_error_o          = err_q;
  assign p_valid_o          = (state_q == ST_RESP);
  assign busy_o             = (count != '0) || (state_q != ST_IDLE);

endmodule
